rpn_sequencer: RTL and testbench

RPN_SEQUENCER -- requirements
Module: rpn_sequencer

---
 rtl/rpn_sequencer_if.sv | 22 ++
 rtl/rpn_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_rpn_sequencer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rpn_sequencer_if.sv
// Calculator-side bus of the RPN sequencer: opcode/operand/apply strobe out,
// tail value and validity flag back. Master is the sequencer, slave the calculator.
interface rpn_sequencer_if #(
    parameter int DATA_W = 8
);
    logic              calc_rst;
    logic [2:0]        calc_op;
    logic [DATA_W-1:0] calc_in;
    logic              calc_apply;
    logic [DATA_W-1:0] calc_tail;
    logic              calc_valid;

    modport master (
        output calc_rst, calc_op, calc_in, calc_apply,
        input  calc_tail, calc_valid
    );

    modport slave (
        input  calc_rst, calc_op, calc_in, calc_apply,
        output calc_tail, calc_valid
    );
endinterface

// File: rtl/rpn_sequencer.sv
// Stores a short stack-calculator program and replays it one instruction per
// two cycles (ISSUE then WAIT), reporting completion, faults and the last tail value.
module rpn_sequencer #(
    parameter int PROG_DEPTH = 16,
    parameter int DATA_W     = 8,
    localparam int CNT_W     = $clog2(PROG_DEPTH + 1),
    localparam int PC_W      = $clog2(PROG_DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                prog_clr,
    input  logic                load_en,
    input  logic [2:0]          load_op,
    input  logic [DATA_W-1:0]   load_data,
    input  logic                start,
    input  logic                abort,
    rpn_sequencer_if.master     calc,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [1:0]          err_code,
    output logic [PC_W-1:0]     err_pc,
    output logic [DATA_W-1:0]   result,
    output logic [CNT_W-1:0]    prog_cnt,
    output logic                load_ovf
);
    typedef enum logic [2:0] {IDLE, CLR, ISSUE, WAIT, DONE, ERR} state_t;

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d, pc_nxt;
    logic [CNT_W-1:0]    run_len_q, run_len_d;
    logic [CNT_W-1:0]    prog_cnt_q, prog_cnt_d;
    logic                load_ovf_q, load_ovf_d;
    logic                calc_rst_q, calc_rst_d;
    logic                calc_apply_q, calc_apply_d;
    logic [2:0]          calc_op_q, calc_op_d;
    logic [DATA_W-1:0]   calc_in_q, calc_in_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic [1:0]          err_code_q, err_code_d;
    logic [PC_W-1:0]     err_pc_q, err_pc_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                wr_en;

    logic [2:0]          prog_op_q  [PROG_DEPTH];
    logic [DATA_W-1:0]   prog_dat_q [PROG_DEPTH];

    assign busy   = (state_q == CLR) || (state_q == ISSUE) || (state_q == WAIT);
    assign pc_nxt = pc_q + PC_W'(1);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        run_len_d    = run_len_q;
        prog_cnt_d   = prog_cnt_q;
        load_ovf_d   = load_ovf_q;
        calc_rst_d   = 1'b0;
        calc_apply_d = 1'b0;
        calc_op_d    = calc_op_q;
        calc_in_d    = calc_in_q;
        done_d       = done_q;
        error_d      = error_q;
        err_code_d   = err_code_q;
        err_pc_d     = err_pc_q;
        result_d     = result_q;
        wr_en        = 1'b0;

        if (!busy) begin
            if (prog_clr) begin
                prog_cnt_d = '0;
                load_ovf_d = 1'b0;
            end else if (load_en) begin
                if (prog_cnt_q == CNT_W'(PROG_DEPTH)) begin
                    load_ovf_d = 1'b1;
                end else begin
                    wr_en      = 1'b1;
                    prog_cnt_d = prog_cnt_q + CNT_W'(1);
                end
            end
        end

        if (busy && abort) begin
            state_d = IDLE;
            done_d  = 1'b0;
            error_d = 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE, ERR: begin
                    // run length uses the count before any same-cycle load
                    if (start && prog_cnt_q == '0) begin
                        state_d    = ERR;
                        done_d     = 1'b0;
                        error_d    = 1'b1;
                        err_code_d = 2'b10;
                        err_pc_d   = '0;
                    end else if (start) begin
                        state_d    = CLR;
                        run_len_d  = prog_cnt_q;
                        calc_rst_d = 1'b1;
                        done_d     = 1'b0;
                        error_d    = 1'b0;
                        err_code_d = 2'b00;
                    end
                end
                CLR: begin
                    state_d      = ISSUE;
                    pc_d         = '0;
                    calc_apply_d = 1'b1;
                    calc_op_d    = prog_op_q[0];
                    calc_in_d    = prog_dat_q[0];
                end
                ISSUE: state_d = WAIT;
                WAIT: begin
                    if (!calc.calc_valid) begin
                        state_d    = ERR;
                        error_d    = 1'b1;
                        err_code_d = 2'b01;
                        err_pc_d   = pc_q;
                    end else begin
                        result_d = calc.calc_tail;
                        if (CNT_W'(pc_q) == run_len_q - CNT_W'(1)) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d      = ISSUE;
                            pc_d         = pc_nxt;
                            calc_apply_d = 1'b1;
                            calc_op_d    = prog_op_q[pc_nxt];
                            calc_in_d    = prog_dat_q[pc_nxt];
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= '0;
            run_len_q    <= '0;
            prog_cnt_q   <= '0;
            load_ovf_q   <= 1'b0;
            calc_rst_q   <= 1'b1;
            calc_apply_q <= 1'b0;
            calc_op_q    <= 3'b000;
            calc_in_q    <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            err_code_q   <= 2'b00;
            err_pc_q     <= '0;
            result_q     <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            run_len_q    <= run_len_d;
            prog_cnt_q   <= prog_cnt_d;
            load_ovf_q   <= load_ovf_d;
            calc_rst_q   <= calc_rst_d;
            calc_apply_q <= calc_apply_d;
            calc_op_q    <= calc_op_d;
            calc_in_q    <= calc_in_d;
            done_q       <= done_d;
            error_q      <= error_d;
            err_code_q   <= err_code_d;
            err_pc_q     <= err_pc_d;
            result_q     <= result_d;
        end
    end

    // program store carries no reset; prog_cnt alone defines its valid extent
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            prog_op_q[prog_cnt_q[PC_W-1:0]]  <= load_op;
            prog_dat_q[prog_cnt_q[PC_W-1:0]] <= load_data;
        end
    end

    assign calc.calc_rst   = calc_rst_q;
    assign calc.calc_apply = calc_apply_q;
    assign calc.calc_op    = calc_op_q;
    assign calc.calc_in    = calc_in_q;
    assign done            = done_q;
    assign error           = error_q;
    assign err_code        = err_code_q;
    assign err_pc          = err_pc_q;
    assign result          = result_q;
    assign prog_cnt        = prog_cnt_q;
    assign load_ovf        = load_ovf_q;
endmodule

// File: tb/tb_rpn_sequencer.sv
// Directed bench for rpn_sequencer with a behavioural stack-calculator stub.
module tb_rpn_sequencer;
    logic       clk = 1'b0;
    logic       rst, prog_clr, load_en, start, abort;
    logic [2:0] load_op;
    logic [7:0] load_data;
    logic       busy, done, error, load_ovf;
    logic [1:0] err_code;
    logic [3:0] err_pc;
    logic [7:0] result;
    logic [4:0] prog_cnt;
    int         n_chk = 0;
    int         n_pass = 0;

    rpn_sequencer_if #(.DATA_W(8)) cif ();

    rpn_sequencer #(.PROG_DEPTH(16), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .prog_clr(prog_clr), .load_en(load_en),
        .load_op(load_op), .load_data(load_data), .start(start), .abort(abort),
        .calc(cif), .busy(busy), .done(done), .error(error), .err_code(err_code),
        .err_pc(err_pc), .result(result), .prog_cnt(prog_cnt), .load_ovf(load_ovf)
    );

    always #5 clk = ~clk;

    // Stack calculator stub: 15-entry stack, validity sticky low on any fault.
    logic [7:0] stk [16];
    logic [3:0] sp = 4'd0;
    bit         vld = 1'b1;

    function automatic bit alu_fault(input logic [2:0] op, input logic [7:0] b);
        return (op == 3'b011 || op == 3'b100) && b == 8'd0;
    endfunction

    function automatic logic [7:0] alu_res(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a * b;
            3'b011:  return a / b;
            default: return a % b;
        endcase
    endfunction

    always @(posedge clk) begin
        if (cif.calc_rst) begin
            sp  <= 4'd0;
            vld <= 1'b1;
        end else if (cif.calc_apply && vld) begin
            case (cif.calc_op)
                3'b101: if (sp == 4'd15) vld <= 1'b0;
                        else begin stk[sp] <= cif.calc_in; sp <= sp + 4'd1; end
                3'b110: if (sp == 4'd0) vld <= 1'b0; else sp <= sp - 4'd1;
                3'b111: vld <= 1'b0;
                default: begin
                    if (sp < 4'd2 || alu_fault(cif.calc_op, stk[sp-4'd1])) vld <= 1'b0;
                    else begin
                        stk[sp-4'd2] <= alu_res(cif.calc_op, stk[sp-4'd2], stk[sp-4'd1]);
                        sp <= sp - 4'd1;
                    end
                end
            endcase
        end
    end

    assign cif.calc_tail  = (sp != 4'd0) ? stk[sp-4'd1] : 8'd0;
    assign cif.calc_valid = vld;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [2:0] op, input logic [7:0] dat);
        load_en = 1'b1; load_op = op; load_data = dat;
        tick();
        load_en = 1'b0;
    endtask

    task automatic clear_prog;
        prog_clr = 1'b1;
        tick();
        prog_clr = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; prog_clr = 0; load_en = 0; load_op = 0; load_data = 0; start = 0; abort = 0;
        tick(); tick();
        n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy got %0b exp 0", busy); else n_pass++;
        n_chk++; if (done !== 1'b0 || error !== 1'b0) $display("FAIL rst_done_err got %0b%0b exp 00", done, error); else n_pass++;
        n_chk++; if (err_code !== 2'b00 || err_pc !== 4'd0) $display("FAIL rst_err_info got %0b/%0d exp 00/0", err_code, err_pc); else n_pass++;
        n_chk++; if (result !== 8'd0) $display("FAIL rst_result got %0d exp 0", result); else n_pass++;
        n_chk++; if (prog_cnt !== 5'd0 || load_ovf !== 1'b0) $display("FAIL rst_prog got %0d/%0b exp 0/0", prog_cnt, load_ovf); else n_pass++;
        n_chk++; if (cif.calc_apply !== 1'b0 || cif.calc_op !== 3'b000 || cif.calc_in !== 8'd0)
            $display("FAIL rst_calc_bus got %0b/%0b/%0d exp 0/000/0", cif.calc_apply, cif.calc_op, cif.calc_in); else n_pass++;
        n_chk++; if (cif.calc_rst !== 1'b1) $display("FAIL rst_calc_rst got %0b exp 1", cif.calc_rst); else n_pass++;
        rst = 1'b0;
        tick();
        n_chk++; if (cif.calc_rst !== 1'b0) $display("FAIL rst_calc_rst_release got %0b exp 0", cif.calc_rst); else n_pass++;
    endtask

    task automatic test_add;
        logic [9:0] rst_m, app_m, done_m, busy_m;
        rst_m = '0; app_m = '0; done_m = '0; busy_m = '0;
        clear_prog();
        load(3'b101, 8'd3); load(3'b101, 8'd4); load(3'b000, 8'd0);
        n_chk++; if (prog_cnt !== 5'd3) $display("FAIL add_prog_cnt got %0d exp 3", prog_cnt); else n_pass++;
        start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            start = 1'b0;
            rst_m[i] = cif.calc_rst; app_m[i] = cif.calc_apply; done_m[i] = done; busy_m[i] = busy;
        end
        n_chk++; if (rst_m !== 10'b0000000001) $display("FAIL add_calc_rst got %b exp 0000000001", rst_m); else n_pass++;
        n_chk++; if (app_m !== 10'b0000101010) $display("FAIL add_apply got %b exp 0000101010", app_m); else n_pass++;
        n_chk++; if (done_m !== 10'b1110000000) $display("FAIL add_done got %b exp 1110000000", done_m); else n_pass++;
        n_chk++; if (busy_m !== 10'b0001111111) $display("FAIL add_busy got %b exp 0001111111", busy_m); else n_pass++;
        n_chk++; if (result !== 8'd7 || error !== 1'b0) $display("FAIL add_result got %0d/err %0b exp 7/0", result, error); else n_pass++;
    endtask

    task automatic test_fault;
        int applies = 0;
        int cyc = 0;
        clear_prog();
        load(3'b101, 8'd5); load(3'b101, 8'd0); load(3'b011, 8'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        n_chk++; if (done !== 1'b0) $display("FAIL fault_done_clear got %0b exp 0", done); else n_pass++;
        while (!error && cyc < 20) begin
            tick();
            cyc++;
            if (cif.calc_apply) applies++;
        end
        n_chk++; if (error !== 1'b1) $display("FAIL fault_error got %0b exp 1 (timeout)", error); else n_pass++;
        n_chk++; if (err_code !== 2'b01 || err_pc !== 4'd2) $display("FAIL fault_code_pc got %0b/%0d exp 01/2", err_code, err_pc); else n_pass++;
        n_chk++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL fault_done_busy got %0b/%0b exp 0/0", done, busy); else n_pass++;
        n_chk++; if (applies != 3) $display("FAIL fault_applies got %0d exp 3", applies); else n_pass++;
        n_chk++; if (result !== 8'd0) $display("FAIL fault_result got %0d exp 0", result); else n_pass++;
    endtask

    task automatic test_overflow;
        clear_prog();
        for (int i = 0; i < 16; i++) load(3'b101, 8'(i));
        n_chk++; if (prog_cnt !== 5'd16 || load_ovf !== 1'b0) $display("FAIL ovf_full got %0d/%0b exp 16/0", prog_cnt, load_ovf); else n_pass++;
        load(3'b101, 8'd99);
        n_chk++; if (prog_cnt !== 5'd16 || load_ovf !== 1'b1) $display("FAIL ovf_17th got %0d/%0b exp 16/1", prog_cnt, load_ovf); else n_pass++;
        prog_clr = 1'b1; load_en = 1'b1;
        tick();
        prog_clr = 1'b0; load_en = 1'b0;
        n_chk++; if (prog_cnt !== 5'd0 || load_ovf !== 1'b0) $display("FAIL ovf_clr_wins got %0d/%0b exp 0/0", prog_cnt, load_ovf); else n_pass++;
    endtask

    task automatic test_empty;
        logic saw_rst, saw_app;
        start = 1'b1;
        tick();
        start = 1'b0;
        saw_rst = cif.calc_rst; saw_app = cif.calc_apply;
        n_chk++; if (error !== 1'b1 || err_code !== 2'b10 || err_pc !== 4'd0)
            $display("FAIL empty_err got %0b/%0b/%0d exp 1/10/0", error, err_code, err_pc); else n_pass++;
        n_chk++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL empty_busy_done got %0b/%0b exp 0/0", busy, done); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            tick();
            saw_rst |= cif.calc_rst; saw_app |= cif.calc_apply;
        end
        n_chk++; if (saw_rst !== 1'b0 || saw_app !== 1'b0) $display("FAIL empty_no_calc got rst %0b apply %0b exp 0/0", saw_rst, saw_app); else n_pass++;
    endtask

    task automatic test_abort;
        int applies = 0;
        int dn_at = -1;
        logic was_busy = 1'b0;
        clear_prog();
        load(3'b101, 8'd2); load(3'b101, 8'd6); load(3'b010, 8'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        load_en = 1'b1; load_op = 3'b101; load_data = 8'd1;
        tick();
        load_en = 1'b0;
        n_chk++; if (prog_cnt !== 5'd3) $display("FAIL abort_load_busy got %0d exp 3", prog_cnt); else n_pass++;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_chk++; if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || cif.calc_apply !== 1'b0)
            $display("FAIL abort_idle got busy %0b done %0b err %0b apply %0b exp 0000", busy, done, error, cif.calc_apply); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (cif.calc_apply) applies++;
            was_busy |= busy;
        end
        n_chk++; if (applies != 0 || was_busy !== 1'b0) $display("FAIL abort_quiet got applies %0d busy %0b exp 0/0", applies, was_busy); else n_pass++;
        n_chk++; if (prog_cnt !== 5'd3) $display("FAIL abort_store_kept got %0d exp 3", prog_cnt); else n_pass++;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 4; j < 16; j++) begin
            tick();
            if (done && dn_at < 0) dn_at = j;
        end
        n_chk++; if (dn_at != 7) $display("FAIL abort_rerun_done_at got %0d exp 7", dn_at); else n_pass++;
        n_chk++; if (result !== 8'd12) $display("FAIL abort_rerun_result got %0d exp 12", result); else n_pass++;
    endtask

    task automatic test_rst_mid;
        clear_prog();
        load(3'b101, 8'd9); load(3'b101, 8'd1); load(3'b001, 8'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        rst = 1'b1; start = 1'b1; abort = 1'b1; load_en = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0; load_en = 1'b0;
        n_chk++; if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) $display("FAIL rstmid_flags got %0b%0b%0b exp 000", busy, done, error); else n_pass++;
        n_chk++; if (prog_cnt !== 5'd0 || load_ovf !== 1'b0) $display("FAIL rstmid_prog got %0d/%0b exp 0/0", prog_cnt, load_ovf); else n_pass++;
        n_chk++; if (result !== 8'd0 || err_code !== 2'b00 || err_pc !== 4'd0)
            $display("FAIL rstmid_regs got %0d/%0b/%0d exp 0/00/0", result, err_code, err_pc); else n_pass++;
        n_chk++; if (cif.calc_rst !== 1'b1 || cif.calc_apply !== 1'b0 || cif.calc_op !== 3'b000 || cif.calc_in !== 8'd0)
            $display("FAIL rstmid_calc got %0b/%0b/%0b/%0d exp 1/0/000/0", cif.calc_rst, cif.calc_apply, cif.calc_op, cif.calc_in); else n_pass++;
        rst = 1'b0;
        tick(); tick();
        n_chk++; if (busy !== 1'b0 || cif.calc_rst !== 1'b0) $display("FAIL rstmid_after got busy %0b calc_rst %0b exp 0/0", busy, cif.calc_rst); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_fault();
        test_overflow();
        test_empty();
        test_abort();
        test_rst_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
